// File: rtl/w_serializer.sv
// Parallel-to-serial converter that feeds one bit per cycle into a downstream
// sequence detector. Back-to-back words stream with no gap between them.
module w_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_W    = 1'b0
) (
  input  logic             clk,
  input  logic             Resetn,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             w,
  output logic             w_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             last;
  logic             xfer;
  logic [WIDTH-1:0] sreg_shifted;

  assign last = (state_q == SHIFT) && (cnt_q == LAST_CNT);
  assign xfer = din_valid && din_ready;

  // Shift toward whichever end drives w, zero-filling the vacated bit.
  assign sreg_shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                                  : {1'b0, sreg_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          sreg_d  = din;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last) begin
          if (xfer) begin
            sreg_d = din;
            cnt_d  = '0;
          end else begin
            sreg_d  = sreg_shifted;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end else begin
          sreg_d = sreg_shifted;
          cnt_d  = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on registered state, never on din/din_valid.
  always_comb begin
    din_ready = (state_q == IDLE) || last;
    busy      = (state_q == SHIFT);
    w_valid   = (state_q == SHIFT);
    done      = last;
    w         = IDLE_W;
    if (state_q == SHIFT) w = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
  end

endmodule

// File: tb/tb_w_serializer.sv
// Directed bench for w_serializer: reset, single word, back-to-back, stall,
// mid-word reset, and an LSB-first instance with a high idle level.
module tb_w_serializer;

  logic       clk = 1'b0;
  logic       Resetn;
  logic [7:0] din, din1;
  logic       din_valid, din_valid1;
  logic       din_ready, w, w_valid, busy, done;
  logic       din_ready1, w1, w_valid1, busy1, done1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  w_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_W(1'b0)) dut (
    .clk(clk), .Resetn(Resetn), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .w(w), .w_valid(w_valid), .busy(busy), .done(done)
  );

  w_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_W(1'b1)) dut1 (
    .clk(clk), .Resetn(Resetn), .din(din1), .din_valid(din_valid1),
    .din_ready(din_ready1), .w(w1), .w_valid(w_valid1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".w"}, w, 1'b0);
    chk({tag, ".w_valid"}, w_valid, 1'b0);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".done"}, done, 1'b0);
    chk({tag, ".din_ready"}, din_ready, 1'b1);
  endtask

  // Call at posedge+1 right after the transfer edge; returns at posedge+1
  // after the last-bit edge. scramble wiggles din with din_valid held high
  // through bits 0..6, then drops din_valid before the last-bit edge.
  task automatic shift_check(input logic [7:0] word, input string tag, input bit scramble);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("%s.w[%0d]", tag, i), w, word[7-i]);
      chk($sformatf("%s.w_valid[%0d]", tag, i), w_valid, 1'b1);
      chk($sformatf("%s.busy[%0d]", tag, i), busy, 1'b1);
      chk($sformatf("%s.done[%0d]", tag, i), done, i == 7);
      chk($sformatf("%s.din_ready[%0d]", tag, i), din_ready, i == 7);
      if (scramble) begin
        din       = 8'($urandom);
        din_valid = (i != 7);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    Resetn = 1'b1; din = 8'h00; din_valid = 1'b0; din1 = 8'h00; din_valid1 = 1'b0;

    // Asynchronous reset mid-cycle
    #2 Resetn = 1'b0;
    #1;
    chk_idle("reset");
    chk("reset.w1_idle_high", w1, 1'b1);
    chk("reset.w_valid1", w_valid1, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    Resetn = 1'b1;
    @(negedge clk);
    chk_idle("post_reset");
    @(posedge clk); #1;

    // Single word
    din = 8'hA5; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0; din = 8'h00;
    shift_check(8'hA5, "single", 1'b0);
    @(negedge clk);
    chk_idle("single_end");
    @(posedge clk); #1;

    // Back-to-back words with din_valid held
    din = 8'hA5; din_valid = 1'b1;
    @(posedge clk); #1;
    din = 8'h3C;
    shift_check(8'hA5, "b2b0", 1'b0);
    din_valid = 1'b0; din = 8'h00;
    shift_check(8'h3C, "b2b1", 1'b0);
    @(negedge clk);
    chk_idle("b2b_end");
    @(posedge clk); #1;

    // Stall: din changes while not ready, word in flight unaffected
    din = 8'hC3; din_valid = 1'b1;
    @(posedge clk); #1;
    shift_check(8'hC3, "stall", 1'b1);
    @(negedge clk);
    chk_idle("stall_end");
    @(posedge clk); #1;

    // Mid-word reset during bit 4 of 8'hFF
    din = 8'hFF; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("midrst.bit4", w, 1'b1);
    #2 Resetn = 1'b0;
    #1;
    chk_idle("midrst");
    @(posedge clk); #1;
    Resetn = 1'b1;
    din = 8'h81; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    shift_check(8'h81, "after_rst", 1'b0);
    @(negedge clk);
    chk_idle("after_rst_end");
    @(posedge clk); #1;

    // LSB-first, idle-high instance
    din1 = 8'h01; din_valid1 = 1'b1;
    @(posedge clk); #1;
    din_valid1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("lsb.w[%0d]", i), w1, i == 0);
      chk($sformatf("lsb.w_valid[%0d]", i), w_valid1, 1'b1);
      chk($sformatf("lsb.done[%0d]", i), done1, i == 7);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("lsb_end.w", w1, 1'b1);
    chk("lsb_end.w_valid", w_valid1, 1'b0);
    chk("lsb_end.busy", busy1, 1'b0);
    chk("lsb_end.din_ready", din_ready1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
